instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
- Parametrised, clocked successor to the combinational byte-array instruction memory.
- Stores program bytes and assembles 32-bit big-endian instructions: the byte at PC becomes bits [31:24].
- Adds a valid/ready fetch handshake with 1-cycle registered latency, a word-write program-load port, misalignment and range faults, and a fetch counter.
- Sits between the PC/fetch stage and the decode stage of the CPU.

Parameters:
- ADDR_W, 32, width of PC and load address.
- DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 4 and at least 4.
- NOP_INST, 32'h0000_0000, instruction returned on a faulted fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted.
- req_pc  in  ADDR_W  byte address of the instruction.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_inst  out  32  fetched instruction, big-endian.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 both.
- load_en  in  1  program-load mode; blocks fetch acceptance.
- load_addr  in  ADDR_W  word-aligned byte address for a load write.
- load_data  in  32  write data, big-endian: bits [31:24] go to load_addr.
- load_be  in  4  byte enables; load_be[3] controls the byte at load_addr.
- load_err  out  1  pulses when a load write is dropped.
- fetch_count  out  32  number of accepted fetch requests.

Behaviour:
- Reset values: resp_valid=0, resp_inst=0, resp_fault=00, load_err=0, fetch_count=0. req_ready=0 while reset is high.
- Memory contents are not changed by reset.
- req_ready = !reset && !load_en && (!resp_valid || resp_ready). This is a combinational pass-through, which gives full throughput of one fetch per cycle.
- Accept condition: req_valid && req_ready.
  - On accept, the response register loads at that edge, so resp_valid=1 in the next cycle with that request's data and fault.
  - fetch_count increments by 1 and wraps at 2^32.
- Response state when no new request is accepted:
  - resp_valid && resp_ready clears resp_valid.
  - resp_valid && !resp_ready holds resp_valid, resp_inst and resp_fault stable.
- Response state machine: EMPTY <-> FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with resp_ready.
  - FULL -> EMPTY on resp_ready without an accept.
  - FULL stays FULL when resp_ready is low.
- Fault rules:
  - Misaligned when req_pc[1:0] != 0.
  - Out of range when req_pc > DEPTH_BYTES-4. The compare is done in ADDR_W+1 bits, so no wrap-around occurs.
  - Any fault: resp_inst = NOP_INST and no memory read. The fault is still counted as a fetch.
- Load writes:
  - A write happens in any cycle with load_en=1 and reset=0. Each enabled byte is written at that edge.
  - If load_addr[1:0] != 0 or load_addr > DEPTH_BYTES-4, no write occurs and load_err=1 for one cycle.
  - load_be=0000 is a legal no-op.
- Simultaneous events:
  - Fetch and load never coincide, because load_en forces req_ready=0.
  - A response already held in FULL keeps the data captured at accept, even if a later load write changes that address.
  - Raising load_en while FULL does not drop the pending response. It drains normally via resp_ready.
- Reset mid-operation drops any pending response (resp_valid=0 on the next cycle). Any load write in the reset cycle is ignored.

Decomposition:
- Package ifm_pkg holds:
  - fault codes FAULT_OK, FAULT_MISALIGN, FAULT_RANGE, FAULT_BOTH;
  - default NOP_INST;
  - a width function for the byte-index width, clog2(DEPTH_BYTES).
- Sub-module imem_byte_array holds the byte storage. It provides:
  - a 4-byte big-endian combinational read at a word index;
  - a synchronous 4-lane byte-enabled write.
- The handshake, fault logic and counter live in instr_fetch_mem.

Test Plan:
- Reset, then load 0x3408000B at address 0 with load_be=1111, then fetch pc=0 with resp_ready=1 -> next cycle resp_valid=1, resp_inst=0x3408000B, resp_fault=00, fetch_count=1.
- Back-to-back fetches pc=0,4,8 with resp_ready=1 (after loading words A,B,C) -> responses A,B,C on three consecutive cycles, req_ready=1 throughout.
- Fetch pc=4, then hold resp_ready=0 for 3 cycles -> resp_inst is stable and req_ready=0. Raise resp_ready -> response consumed; req_ready=1 in the same cycle.
- Fetch pc=2 -> resp_fault=01, resp_inst=0x00000000. Fetch pc=DEPTH_BYTES (256) -> resp_fault=10. Fetch pc=254 -> resp_fault=11. fetch_count advances by 3.
- Load 0xAABBCCDD at address 8 with load_be=0101 over the old value 0x11223344 -> a fetch of pc=8 returns 0x11BB33DD. Load at address 6 -> load_err pulses and memory is unchanged.
- Accept fetch pc=0, assert reset in the next cycle -> resp_valid=0 and fetch_count=0 after that edge, and memory still returns the word loaded earlier.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared types and sizing helpers for the instruction fetch memory.
// Fault codes match the 2-bit resp_fault encoding: {out_of_range, misaligned}.
package ifm_pkg;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_BOTH     = 2'b11
  } fault_e;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

  function automatic int byte_idx_w(input int depth_bytes);
    return (depth_bytes > 1) ? $clog2(depth_bytes) : 1;
  endfunction

  // Word index drops the two byte-offset bits; never narrower than one bit.
  function automatic int word_idx_w(input int depth_bytes);
    return (byte_idx_w(depth_bytes) > 2) ? byte_idx_w(depth_bytes) - 2 : 1;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte storage as four byte lanes; lane 3 holds the byte at the word address,
// so the combinational read is big-endian. No reset: contents survive it.
module imem_byte_array
  import ifm_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WORD_IDX_W  = word_idx_w(DEPTH_BYTES)
) (
  input  logic                  clk,
  input  logic [WORD_IDX_W-1:0] rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [WORD_IDX_W-1:0] wr_idx,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data
);

  localparam int NUM_WORDS = DEPTH_BYTES / 4;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_q [NUM_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[l]) lane_q[wr_idx] <= wr_data[8*l +: 8];
    end

    assign rd_data[8*l +: 8] = lane_q[rd_idx];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory: valid/ready fetch with one registered response
// slot, word-write program load, misalign/range faults and a fetch counter.
module instr_fetch_mem
  import ifm_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [1:0]        resp_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [3:0]        load_be,
  output logic              load_err,
  output logic [31:0]       fetch_count
);

  localparam int              WIW       = word_idx_w(DEPTH_BYTES);
  // One extra bit so addresses near 2^ADDR_W cannot wrap into range.
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH_BYTES - 4);

  resp_state_e state_q, state_d;
  logic [31:0] inst_q, inst_d;
  fault_e      fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load_err_q, load_err_d;

  logic           accept, pc_mis, pc_oor, ld_bad, wr_en;
  fault_e         pc_fault;
  logic [31:0]    rd_data;
  logic [WIW-1:0] rd_idx, wr_idx;

  assign resp_valid  = (state_q == RESP_FULL);
  assign resp_inst   = inst_q;
  assign resp_fault  = fault_q;
  assign load_err    = load_err_q;
  assign fetch_count = cnt_q;
  assign req_ready   = !reset && !load_en && (!resp_valid || resp_ready);
  assign accept      = req_valid && req_ready;

  always_comb begin
    pc_mis   = |req_pc[1:0];
    pc_oor   = {1'b0, req_pc} > LAST_WORD;
    pc_fault = fault_e'({pc_oor, pc_mis});
    rd_idx   = WIW'(req_pc >> 2);
    ld_bad   = (|load_addr[1:0]) || ({1'b0, load_addr} > LAST_WORD);
    wr_idx   = WIW'(load_addr >> 2);
    wr_en    = load_en && !reset && !ld_bad;
  end

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    load_err_d = load_en && ld_bad;
    if (accept) begin
      state_d = RESP_FULL;
      inst_d  = (pc_fault == FAULT_OK) ? rd_data : NOP_INST;
      fault_d = pc_fault;
      cnt_d   = cnt_q + 32'd1;
    end else if (state_q == RESP_FULL && resp_ready) begin
      state_d = RESP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESP_EMPTY;
      inst_q     <= '0;
      fault_q    <= FAULT_OK;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WORD_IDX_W  (WIW)
  ) u_mem (
    .clk     (clk),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_be   (load_be),
    .wr_data (load_data)
  );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: byte-level reference memory and a
// scoreboard queue of expected responses, checked with immediate assertions.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, load_en, load_err;
  logic [31:0] req_pc, resp_inst, load_addr, load_data, fetch_count;
  logic [1:0]  resp_fault;
  logic [3:0]  load_be;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] pc_list[$];
  logic [7:0]  mem_m [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 clk = ~clk;

  instr_fetch_mem dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pc      (req_pc),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_inst   (resp_inst),
    .resp_fault  (resp_fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_be     (load_be),
    .load_err    (load_err),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] m_fault(input logic [31:0] pc);
    return {({1'b0, pc} > 33'd252), (pc[1:0] != 2'b00)};
  endfunction

  function automatic logic [31:0] m_inst(input logic [31:0] pc);
    if (m_fault(pc) != 2'b00) return 32'h0;
    return {mem_m[pc[7:0]], mem_m[pc[7:0] + 8'd1], mem_m[pc[7:0] + 8'd2], mem_m[pc[7:0] + 8'd3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] pc);
    sb_q.push_back('{inst: m_inst(pc), fault: m_fault(pc)});
    exp_cnt++;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    n_checks++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_inst"}, resp_inst, e.inst);
      chk({tag, "_fault"}, {30'b0, resp_fault}, {30'b0, e.fault});
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic bad;
    bad       = (a[1:0] != 2'b00) || (a > 32'd252);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    load_be   = be;
    #1 chk("load_req_ready", {31'b0, req_ready}, 32'd0);
    step();
    load_en = 1'b0;
    load_be = 4'b0;
    #1 chk("load_err", {31'b0, load_err}, {31'b0, bad});
    if (!bad)
      for (int k = 0; k < 4; k++)
        if (be[3-k]) mem_m[a[7:0] + 8'(k)] = d[31-8*k -: 8];
  endtask

  task automatic fetch_exp(input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] fault);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_pc     = pc;
    #1 chk("fetch_req_ready", {31'b0, req_ready}, 32'd1);
    sb_q.push_back('{inst: inst, fault: fault});
    exp_cnt++;
    step();
    req_valid = 1'b0;
    #1 pop_check("fetch");
    step();
  endtask

  task automatic run_fetches();
    int n;
    n = pc_list.size();
    resp_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        req_valid = 1'b1;
        req_pc    = pc_list[i];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i > 0) pop_check("b2b");
      if (i < n) begin
        chk("b2b_req_ready", {31'b0, req_ready}, 32'd1);
        sb_push(pc_list[i]);
      end
      step();
    end
    #1;
    chk("b2b_drained", {31'b0, resp_valid}, 32'd0);
    chk("b2b_fetch_count", fetch_count, exp_cnt);
    pc_list.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; load_be = '0;
    step();
    step();
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_inst", resp_inst, 32'h0);
    chk("rst_resp_fault", {30'b0, resp_fault}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;

    // basic load then single fetch
    do_load(32'd0, 32'h3408_000B, 4'b1111);
    fetch_exp(32'd0, 32'h3408_000B, 2'b00);
    #1 chk("first_fetch_count", fetch_count, 32'd1);

    // back-to-back fetches
    do_load(32'd4, 32'hCAFE_F00D, 4'b1111);
    do_load(32'd8, 32'h1122_3344, 4'b1111);
    do_load(32'd252, 32'h5A5A_1234, 4'b1111);
    pc_list = '{32'd0, 32'd4, 32'd8};
    run_fetches();

    // backpressure: response held, new request blocked
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'd4;
    #1 chk("stall_accept_ready", {31'b0, req_ready}, 32'd1);
    sb_push(32'd4);
    step();
    req_pc = 32'd8;
    repeat (3) begin
      #1;
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_inst", resp_inst, 32'hCAFE_F00D);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    #1 chk("stall_fetch_count", fetch_count, exp_cnt);
    resp_ready = 1'b1;
    #1 chk("release_req_ready", {31'b0, req_ready}, 32'd1);
    pop_check("stall");
    sb_push(32'd8);
    step();
    req_valid = 1'b0;
    #1 pop_check("after_stall");
    step();
    #1 chk("after_stall_empty", {31'b0, resp_valid}, 32'd0);

    // load while FULL keeps the captured response
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'd4;
    #1 sb_push(32'd4);
    step();
    req_valid = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'd4;
    load_data = 32'h0BAD_C0DE;
    load_be   = 4'b1111;
    #1 chk("full_load_req_ready", {31'b0, req_ready}, 32'd0);
    step();
    load_en = 1'b0;
    load_be = 4'b0;
    for (int k = 0; k < 4; k++) mem_m[4 + k] = load_data[31-8*k -: 8];
    #1 pop_check("hold_over_load");
    resp_ready = 1'b1;
    step();
    #1 chk("hold_drained", {31'b0, resp_valid}, 32'd0);

    // faults, in-range boundary and no-wrap high address
    pc_list = '{32'd2, 32'd256, 32'd254, 32'd252, 32'hFFFF_FFFC};
    run_fetches();

    // partial byte-enable write, bad load addresses, empty enable
    do_load(32'd8, 32'hAABB_CCDD, 4'b0101);
    fetch_exp(32'd8, 32'h11BB_33DD, 2'b00);
    do_load(32'd6, 32'hFFFF_FFFF, 4'b1111);
    step();
    #1 chk("load_err_pulse_end", {31'b0, load_err}, 32'd0);
    do_load(32'd256, 32'hFFFF_FFFF, 4'b1111);
    do_load(32'd0, 32'hFFFF_FFFF, 4'b0000);
    pc_list = '{32'd4, 32'd8, 32'd0};
    run_fetches();

    // reset mid-operation drops the response, ignores the load, keeps memory
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_pc     = 32'd0;
    step();
    req_valid = 1'b0;
    #1 chk("pre_reset_valid", {31'b0, resp_valid}, 32'd1);
    reset     = 1'b1;
    load_en   = 1'b1;
    load_addr = 32'd0;
    load_data = 32'hDEAD_BEEF;
    load_be   = 4'b1111;
    #1 chk("in_reset_req_ready", {31'b0, req_ready}, 32'd0);
    step();
    reset   = 1'b0;
    load_en = 1'b0;
    load_be = 4'b0;
    #1;
    chk("post_reset_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_reset_count", fetch_count, 32'd0);
    chk("post_reset_inst", resp_inst, 32'h0);
    exp_cnt = 0;
    fetch_exp(32'd0, 32'h3408_000B, 2'b00);
    #1 chk("post_reset_fetch_count", fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
